// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: operation codes, FSM
// states and the datapath width tied to the CPU word size.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

package div_unit_pkg;

  localparam int DIV_DATA_W = `CPU_WIDTH;
  localparam int DIV_CNT_W  = $clog2(DIV_DATA_W);

  // RV32M division operations; bit 1 selects remainder, bit 0 unsigned.
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } div_state_e;

  function automatic logic op_is_signed(input div_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring division iteration: shift {rem, quo} left by one,
// then subtract the divisor from the partial remainder when it fits.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic [DATA_W-1:0] quo_next
);

  logic [DATA_W:0] rem_shifted;
  logic [DATA_W:0] rem_diff;
  logic            fits;

  // The partial remainder is always below the divisor, so the shifted value
  // needs one extra bit and either outcome fits back into DATA_W bits.
  always_comb begin
    rem_shifted = {rem, quo[DATA_W-1]};
    rem_diff    = rem_shifted - {1'b0, divisor};
    fits        = (rem_shifted >= {1'b0, divisor});
    rem_next    = fits ? rem_diff[DATA_W-1:0] : rem_shifted[DATA_W-1:0];
    quo_next    = {quo[DATA_W-2:0], fits};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU). Operands are latched on
// start; special cases resolve in one cycle, everything else runs DATA_W
// restoring iterations on magnitudes followed by a sign fix-up.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = DIV_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              div_start_i,
  input  logic [1:0]        div_op_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] div_result_o,
  output logic              div_res_ready_o,
  output logic              div_busy_o
);

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

  div_state_e        state_reg, state_next;
  div_op_e           op_reg;
  logic [DATA_W-1:0] rem_reg;
  logic [DATA_W-1:0] quo_reg;
  logic [DATA_W-1:0] divisor_reg;
  logic              dividend_neg_reg;
  logic              divisor_neg_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] result_reg;

  div_op_e           op_in;
  logic              in_signed;
  logic              in_dividend_neg;
  logic              in_divisor_neg;
  logic              div_by_zero;
  logic              overflow;
  logic              special;
  logic [DATA_W-1:0] special_result;

  logic [DATA_W-1:0] step_rem;
  logic [DATA_W-1:0] step_quo;
  logic              last_iter;
  logic [DATA_W-1:0] final_result;

  div_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .divisor  (divisor_reg),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Classify the incoming request and precompute the fast-path result.
  always_comb begin
    op_in           = div_op_e'(div_op_i);
    in_signed       = op_is_signed(op_in);
    in_dividend_neg = in_signed & dividend_i[DATA_W-1];
    in_divisor_neg  = in_signed & divisor_i[DATA_W-1];
    div_by_zero     = (divisor_i == '0);
    overflow        = in_signed && (dividend_i == MOST_NEG) && (divisor_i == ALL_ONES);
    special         = div_by_zero | overflow;
    special_result  = '0;
    if (div_by_zero) begin
      special_result = op_is_rem(op_in) ? dividend_i : ALL_ONES;
    end else if (overflow) begin
      special_result = op_is_rem(op_in) ? '0 : MOST_NEG;
    end
  end

  // Apply the sign fix-up to the result of the final iteration.
  always_comb begin
    last_iter    = (cnt_reg == LAST_CNT);
    final_result = '0;
    if (op_is_rem(op_reg)) begin
      final_result = (op_reg == OP_REM && dividend_neg_reg) ? -step_rem : step_rem;
    end else begin
      final_result = (op_reg == OP_DIV && (dividend_neg_reg ^ divisor_neg_reg))
                     ? -step_quo : step_quo;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and status outputs; dropping start mid-CALC aborts.
  always_comb begin
    state_next      = state_reg;
    div_res_ready_o = 1'b0;
    div_busy_o      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (div_start_i) begin
          state_next = special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        div_busy_o = 1'b1;
        if (!div_start_i) begin
          state_next = S_IDLE;
        end else if (last_iter) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        div_busy_o      = 1'b1;
        div_res_ready_o = 1'b1;
        state_next      = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operand latching, iteration datapath and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg           <= OP_DIV;
      rem_reg          <= '0;
      quo_reg          <= '0;
      divisor_reg      <= '0;
      dividend_neg_reg <= 1'b0;
      divisor_neg_reg  <= 1'b0;
      cnt_reg          <= '0;
      result_reg       <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (div_start_i) begin
            op_reg           <= op_in;
            dividend_neg_reg <= in_dividend_neg;
            divisor_neg_reg  <= in_divisor_neg;
            quo_reg          <= in_dividend_neg ? -dividend_i : dividend_i;
            divisor_reg      <= in_divisor_neg ? -divisor_i : divisor_i;
            rem_reg          <= '0;
            cnt_reg          <= '0;
            if (special) begin
              result_reg <= special_result;
            end
          end
        end
        S_CALC: begin
          if (div_start_i) begin
            rem_reg <= step_rem;
            quo_reg <= step_quo;
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (last_iter) begin
              result_reg <= final_result;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign div_result_o = result_reg;

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit: each step drives a request right after a
// rising edge (edge 0) and counts edges until the ready pulse is observed.
module tb_div_unit;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  logic        clk;
  logic        rst;
  logic        div_start;
  logic [1:0]  div_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] div_result;
  logic        div_res_ready;
  logic        div_busy;

  int n_checks = 0;
  int n_fail   = 0;

  div_unit dut (
    .clk             (clk),
    .rst             (rst),
    .div_start_i     (div_start),
    .div_op_i        (div_op),
    .dividend_i      (dividend),
    .divisor_i       (divisor),
    .div_result_o    (div_result),
    .div_res_ready_o (div_res_ready),
    .div_busy_o      (div_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its ready pulse; returns one
  // edge after the pulse with start still high, so a following call is a
  // back-to-back request.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int          lat;
    logic [31:0] res;
    logic        busy_first;
    lat        = 0;
    res        = '0;
    busy_first = 1'b0;
    div_op     = op;
    dividend   = a;
    divisor    = b;
    div_start  = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) busy_first = div_busy;
      if (div_res_ready) begin
        lat = i;
        res = div_result;
        break;
      end
    end
    $display("op %s: a=0x%08h b=0x%08h result=0x%08h latency=%0d", tag, a, b, res, lat);
    check({tag, " result"}, res, exp_res);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy"}, {31'd0, busy_first}, 32'd1);
    @(posedge clk);
    #1;
    check({tag, " pulse_width"}, {31'd0, div_res_ready}, 32'd0);
    check({tag, " busy_after"}, {31'd0, div_busy}, 32'd0);
    check({tag, " result_hold"}, div_result, exp_res);
  endtask

  // Drop start and confirm no ready pulse appears for n cycles.
  task automatic idle(input string tag, input int n);
    int pulses;
    pulses    = 0;
    div_start = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (div_res_ready) pulses++;
    end
    check({tag, " no_pulse"}, 32'(pulses), 32'd0);
  endtask

  initial begin
    int pulses;
    rst       = 1'b1;
    div_start = 1'b0;
    div_op    = DIV;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    $display("reset: result=0x%08h ready=%0b busy=%0b", div_result, div_res_ready, div_busy);
    check("reset result", div_result, 32'h0);
    check("reset ready", {31'd0, div_res_ready}, 32'd0);
    check("reset busy", {31'd0, div_busy}, 32'd0);
    rst = 1'b0;

    run_op("DIVU 100/7", DIVU, 32'd100, 32'd7, 32'h0000000E, 33);
    idle("post DIVU", 2);
    run_op("REM -7/2", REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    idle("post REM", 1);
    run_op("DIV -7/2", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);

    run_op("DIVU 5/0", DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_op("REMU 5/0", REMU, 32'd5, 32'd0, 32'h00000005, 1);
    run_op("DIV -5/0", DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 1);
    run_op("DIV ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("REM ovf", REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    run_op("DIV 100/-7", DIV, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 33);
    run_op("REM -100/7", REM, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 33);
    run_op("REMU big/16", REMU, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 33);
    idle("post REMU", 2);

    // Abort: drop start after edge 10 of a DIVU 1000/3.
    pulses    = 0;
    div_op    = DIVU;
    dividend  = 32'd1000;
    divisor   = 32'd3;
    div_start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (div_res_ready) pulses++;
    end
    check("abort busy_before", {31'd0, div_busy}, 32'd1);
    div_start = 1'b0;
    @(posedge clk);
    #1;
    if (div_res_ready) pulses++;
    $display("abort: busy=%0b result=0x%08h", div_busy, div_result);
    check("abort busy_after", {31'd0, div_busy}, 32'd0);
    check("abort pulses", 32'(pulses), 32'd0);
    idle("abort tail", 40);
    check("abort result_kept", div_result, 32'h0000000F);
    run_op("DIVU 9/3", DIVU, 32'd9, 32'd3, 32'h00000003, 33);
    idle("post 9/3", 1);

    // Reset in the middle of a DIV.
    div_op    = DIV;
    dividend  = 32'hFFFFFF9C;
    divisor   = 32'd7;
    div_start = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    $display("mid reset: result=0x%08h ready=%0b busy=%0b", div_result, div_res_ready, div_busy);
    check("midrst result", div_result, 32'h0);
    check("midrst ready", {31'd0, div_res_ready}, 32'd0);
    check("midrst busy", {31'd0, div_busy}, 32'd0);
    div_start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle("after midrst", 40);

    // Back-to-back pair.
    run_op("DIVU b2b 100/7", DIVU, 32'd100, 32'd7, 32'h0000000E, 33);
    run_op("REMU b2b 100/7", REMU, 32'd100, 32'd7, 32'h00000002, 33);
    idle("end", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle integer divider that answers the ALU core's division requests: DIV, DIVU, REM and REMU (RV32M semantics).
- The ALU drives `div_start`, dividend and divisor combinationally, and holds them until the divider returns `div_res_ready` with the result.
- Implemented as a radix-2 restoring divider producing one quotient bit per cycle, with a single-cycle fast path for the special cases.

Parameters:
- DATA_W, 32, operand/result width; equals `CPU_WIDTH.
- CNT_W, 5, iteration counter width; equals log2(DATA_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- div_start_i  in  1  request from ALU; level, held high until result is accepted.
- div_op_i  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend_i  in  DATA_W  dividend (rs1).
- divisor_i  in  DATA_W  divisor (rs2).
- div_result_o  out  DATA_W  quotient or remainder, per the latched op.
- div_res_ready_o  out  1  one-cycle pulse; div_result_o is valid in this cycle.
- div_busy_o  out  1  high in CALC and DONE.

Behaviour:
- Reset (async, rst=1): state=IDLE; div_result_o=0, div_res_ready_o=0, div_busy_o=0; all internal registers and counter cleared. Reset asserted mid-operation discards the operation and produces no ready pulse.
- States: IDLE, CALC, DONE.
- IDLE:
  - On div_start_i=1 at a rising edge, latch op, dividend, divisor and both sign bits.
  - Special cases go straight to DONE with the result precomputed.
    - divisor==0: quotient=all ones; remainder=dividend (both signed and unsigned).
    - DIV/REM with dividend=0x80000000 and divisor=0xFFFFFFFF: quotient=0x80000000; remainder=0.
  - Otherwise go to CALC:
    - For signed ops, load |dividend| and |divisor| (two's-complement negate when the sign bit is set).
    - partial remainder=0; counter=0.
- CALC: each cycle
  - shift {rem, quo} left by 1, bringing in the dividend MSB;
  - if rem_shifted >= divisor_abs, then rem=rem_shifted-divisor_abs and quotient bit=1, else quotient bit=0;
  - counter+1. After DATA_W iterations (counter==DATA_W-1 processed), go to DONE.
- Sign fix-up, applied on the DONE transition:
  - quotient negated when DIV and sign(dividend)!=sign(divisor);
  - remainder negated when REM and the dividend was negative.
  - Unsigned ops never fix up.
- DONE: div_res_ready_o=1 and div_result_o=the selected result for exactly one cycle; then unconditionally return to IDLE.
- Output hold: div_result_o holds its value until the next DONE. div_res_ready_o=0 in all other states.
- Latency:
  - Normal case: start sampled at edge 0; ready is high in the cycle after edge 33 (DATA_W CALC cycles plus 1 DONE cycle).
  - Special case: ready in the cycle after edge 1.
- Abort: div_start_i=0 during CALC returns to IDLE at the next edge, with no ready pulse and no result update. This covers ALU flush or op change.
- Operand changes during CALC are ignored; the latched copies are used.
- div_start_i is ignored in DONE. Back-to-back: start high in the cycle after DONE is accepted from IDLE normally.
- Arithmetic: all internal datapaths are DATA_W bits, with a DATA_W+1-bit compare/subtract for the remainder. No X propagation; every register has a reset value.

Decomposition:
- Shared defines/package: DIV op encodings (DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11), FSM state encodings, and the DATA_W tie to `CPU_WIDTH.
- One natural sub-module, div_step: combinational single-iteration shift/compare/subtract.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
- Everything else (FSM, counter, sign handling, special-case detection) stays in div_unit.

Test Plan:
- DIVU 100/7, start held high -> ready pulses once at cycle 33 with 0x0000000E; busy high cycles 1–33.
- REM 0xFFFFFFF9 (-7) / 2 -> result 0xFFFFFFFF (-1). DIV same operands -> 0xFFFFFFFD (-3).
- Divide by zero:
  - DIVU 5/0 -> 0xFFFFFFFF;
  - REMU 5/0 -> 0x00000005;
  - DIV -5/0 -> 0xFFFFFFFF.
  - All with ready at cycle 1.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0x00000000; ready at cycle 1.
- Abort: start DIVU 1000/3, drop start at cycle 10 -> no ready pulse, state IDLE. A new DIVU 9/3 then returns 0x00000003 at cycle 33 from its own start.
- Reset mid-op: assert rst at cycle 15 of a DIV -> all outputs 0 immediately; no ready pulse after release. A back-to-back DIVU/REMU pair completes correctly.
